// File: rtl/mipi_tx_pkg.sv
// Shared types for the D-PHY transmit lane controllers: sequencer states,
// LP line-state encodings and the registered pad-control bundle.
package mipi_tx_pkg;

  typedef enum logic [3:0] {
    STOP, HS_RQST, HS_PREP, HS_ZERO, HS_PRE, HS_CLK,
    HS_POST, HS_TRAIL, HS_EXIT, ULPS_RQST, ULPS, ULPS_EXIT
  } state_t;

  // {DTXLPP, DTXLPN}
  typedef logic [1:0] lp_t;
  localparam lp_t LP11 = 2'b11;
  localparam lp_t LP10 = 2'b10;
  localparam lp_t LP01 = 2'b01;
  localparam lp_t LP00 = 2'b00;

  typedef struct packed {
    lp_t  lp;
    logic lpen;
    logic hsen;
    logic gate;
    logic clkact;
    logic stop;
    logic ulpsn;
  } pad_ctrl_t;

  localparam pad_ctrl_t PAD_RESET = '{lp: LP11, lpen: 1'b1, hsen: 1'b0, gate: 1'b1,
                                      clkact: 1'b0, stop: 1'b1, ulpsn: 1'b1};

  // Moore decode; LP lines are parked at LP-00 whenever the LP driver is off.
  function automatic pad_ctrl_t pad_decode(state_t s);
    pad_ctrl_t p;
    p      = PAD_RESET;
    p.stop = 1'b0;
    case (s)
      STOP:      p.stop = 1'b1;
      HS_RQST:   p.lp = LP01;
      HS_PREP:   p.lp = LP00;
      HS_ZERO, HS_TRAIL: begin
        p.lp = LP00; p.lpen = 1'b0; p.hsen = 1'b1;
      end
      HS_PRE, HS_POST: begin
        p.lp = LP00; p.lpen = 1'b0; p.hsen = 1'b1; p.gate = 1'b0;
      end
      HS_CLK: begin
        p.lp = LP00; p.lpen = 1'b0; p.hsen = 1'b1; p.gate = 1'b0; p.clkact = 1'b1;
      end
      ULPS_RQST: p.lp = LP10;
      ULPS: begin
        p.lp = LP00; p.ulpsn = 1'b0;
      end
      ULPS_EXIT: begin
        p.lp = LP10; p.ulpsn = 1'b0;
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mipi_clock_lane_tx_ctrl_if.sv
// PPI request inputs and clock-lane pad controls of the clock-lane transmitter.
interface mipi_clock_lane_tx_ctrl_if;
  logic TXREQUESTHS;
  logic TXULPSCLK;
  logic TXULPSEXIT;
  logic DTXLPP;
  logic DTXLPN;
  logic TXLPEN;
  logic TXHSEN;
  logic TXHSPD;
  logic TXHSGATE;
  logic CLKACTIVE;
  logic STOPSTATE;
  logic ULPSACTIVENOT;

  modport master (
    output TXREQUESTHS, TXULPSCLK, TXULPSEXIT,
    input  DTXLPP, DTXLPN, TXLPEN, TXHSEN, TXHSPD, TXHSGATE,
           CLKACTIVE, STOPSTATE, ULPSACTIVENOT
  );

  modport slave (
    input  TXREQUESTHS, TXULPSCLK, TXULPSEXIT,
    output DTXLPP, DTXLPN, TXLPEN, TXHSEN, TXHSPD, TXHSGATE,
           CLKACTIVE, STOPSTATE, ULPSACTIVENOT
  );
endinterface

// File: rtl/mipi_tx_timer.sv
// Loadable down-counter with zero flag; counts down to 0 and holds there.
module mipi_tx_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)            cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mipi_clock_lane_tx_ctrl.sv
// Master clock-lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS-0 -> clock -> trail
// -> LP-11, plus ULPS entry/exit. Outputs are registered decodes of next state.
module mipi_clock_lane_tx_ctrl
  import mipi_tx_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int T_LPX         = 2,
  parameter int T_CLK_PREPARE = 3,
  parameter int T_CLK_ZERO    = 10,
  parameter int T_CLK_PRE     = 4,
  parameter int T_CLK_POST    = 6,
  parameter int T_CLK_TRAIL   = 3,
  parameter int T_HS_EXIT     = 5,
  parameter int T_WAKEUP      = 20
) (
  input logic                     BYTECLK,
  input logic                     RST_N,
  mipi_clock_lane_tx_ctrl_if.slave ppi
);
  typedef logic [CNT_W-1:0] cnt_t;

  state_t    state_q, state_d;
  pad_ctrl_t pad_q;
  logic      tmr_zero, tmr_load;
  cnt_t      tmr_val;

  // Load value makes a timed state last exactly T cycles.
  function automatic cnt_t dwell(state_t s);
    case (s)
      HS_RQST, ULPS_RQST: return cnt_t'(T_LPX - 1);
      HS_PREP:            return cnt_t'(T_CLK_PREPARE - 1);
      HS_ZERO:            return cnt_t'(T_CLK_ZERO - 1);
      HS_PRE:             return cnt_t'(T_CLK_PRE - 1);
      HS_POST:            return cnt_t'(T_CLK_POST - 1);
      HS_TRAIL:           return cnt_t'(T_CLK_TRAIL - 1);
      HS_EXIT:            return cnt_t'(T_HS_EXIT - 1);
      ULPS_EXIT:          return cnt_t'(T_WAKEUP - 1);
      default:            return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP: begin
        if (ppi.TXREQUESTHS)    state_d = HS_RQST;
        else if (ppi.TXULPSCLK) state_d = ULPS_RQST;
      end
      HS_RQST:   if (tmr_zero) state_d = HS_PREP;
      HS_PREP:   if (tmr_zero) state_d = HS_ZERO;
      HS_ZERO:   if (tmr_zero) state_d = HS_PRE;
      HS_PRE:    if (tmr_zero) state_d = HS_CLK;
      HS_CLK:    if (!ppi.TXREQUESTHS) state_d = HS_POST;
      HS_POST:   if (tmr_zero) state_d = HS_TRAIL;
      HS_TRAIL:  if (tmr_zero) state_d = HS_EXIT;
      HS_EXIT:   if (tmr_zero) state_d = STOP;
      ULPS_RQST: if (tmr_zero) state_d = ULPS;
      ULPS:      if (ppi.TXULPSEXIT) state_d = ULPS_EXIT;
      ULPS_EXIT: if (tmr_zero) state_d = STOP;
      default:   state_d = STOP;
    endcase
  end

  assign tmr_load = (state_d != state_q);
  assign tmr_val  = dwell(state_d);

  mipi_tx_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (BYTECLK),
    .rst_n_i    (RST_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge BYTECLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= STOP;
      pad_q   <= PAD_RESET;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_decode(state_d);
    end
  end

  assign ppi.DTXLPP        = pad_q.lp[1];
  assign ppi.DTXLPN        = pad_q.lp[0];
  assign ppi.TXLPEN        = pad_q.lpen;
  assign ppi.TXHSEN        = pad_q.hsen;
  assign ppi.TXHSPD        = ~pad_q.hsen;
  assign ppi.TXHSGATE      = pad_q.gate;
  assign ppi.CLKACTIVE     = pad_q.clkact;
  assign ppi.STOPSTATE     = pad_q.stop;
  assign ppi.ULPSACTIVENOT = pad_q.ulpsn;
endmodule

// File: tb/tb_mipi_clock_lane_tx_ctrl.sv
// Clock-lane sequencer bench: a per-cycle output-sequence model (queue of
// expected pad vectors) checked every cycle, plus literal latency pins.
module tb_mipi_clock_lane_tx_ctrl;
  localparam int T_LPX = 2, T_PREP = 3, T_ZERO = 10, T_PRE = 4;
  localparam int T_POST = 6, T_TRAIL = 3, T_EXIT = 5, T_WAKE = 20;

  logic BYTECLK, RST_N;
  mipi_clock_lane_tx_ctrl_if ppi();

  mipi_clock_lane_tx_ctrl #(
    .CNT_W(16), .T_LPX(T_LPX), .T_CLK_PREPARE(T_PREP), .T_CLK_ZERO(T_ZERO),
    .T_CLK_PRE(T_PRE), .T_CLK_POST(T_POST), .T_CLK_TRAIL(T_TRAIL),
    .T_HS_EXIT(T_EXIT), .T_WAKEUP(T_WAKE)
  ) dut (.BYTECLK(BYTECLK), .RST_N(RST_N), .ppi(ppi));

  initial BYTECLK = 1'b0;
  always #5 BYTECLK = ~BYTECLK;

  int total = 0, bad = 0;
  bit cmp_en = 1'b0;

  // Vector layout: {LPP, LPN, LPEN, HSEN, HSPD, GATE, CLKACTIVE, STOPSTATE, ULPSACTIVENOT}
  function automatic logic [8:0] mk(logic [1:0] lp, logic lpen, logic hsen, logic gate,
                                    logic ca, logic st, logic un);
    return {lp, lpen, hsen, ~hsen, gate, ca, st, un};
  endfunction

  localparam logic [8:0] STOPV  = 9'b11_1_0_1_1_0_1_1;
  logic [8:0] LP01V, LP00V, HS0V, GATE0V, CLKV, EXITV, URQV, ULPSV, UEXITV;
  initial begin
    LP01V  = mk(2'b01, 1, 0, 1, 0, 0, 1);
    LP00V  = mk(2'b00, 1, 0, 1, 0, 0, 1);
    HS0V   = mk(2'b00, 0, 1, 1, 0, 0, 1);
    GATE0V = mk(2'b00, 0, 1, 0, 0, 0, 1);
    CLKV   = mk(2'b00, 0, 1, 0, 1, 0, 1);
    EXITV  = mk(2'b11, 1, 0, 1, 0, 0, 1);
    URQV   = mk(2'b10, 1, 0, 1, 0, 0, 1);
    ULPSV  = mk(2'b00, 1, 0, 1, 0, 0, 0);
    UEXITV = mk(2'b10, 1, 0, 1, 0, 0, 0);
  end

  logic [8:0] dut_vec;
  assign dut_vec = {ppi.DTXLPP, ppi.DTXLPN, ppi.TXLPEN, ppi.TXHSEN, ppi.TXHSPD,
                    ppi.TXHSGATE, ppi.CLKACTIVE, ppi.STOPSTATE, ppi.ULPSACTIVENOT};

  // Model: each accepted request expands into the full per-cycle output
  // sequence; when the queue is empty the lane rests in a steady mode.
  typedef enum {M_STOP, M_CLK, M_ULPS} mode_t;
  mode_t      mode;
  logic [8:0] q[$];
  logic [8:0] expv;

  task automatic push_n(input logic [8:0] v, input int n);
    for (int i = 0; i < n; i++) q.push_back(v);
  endtask

  always @(posedge BYTECLK or negedge RST_N) begin
    if (!RST_N) begin
      q.delete(); mode = M_STOP; expv = STOPV;
    end else begin
      if (q.size() == 0) begin
        case (mode)
          M_STOP:
            if (ppi.TXREQUESTHS) begin
              push_n(LP01V, T_LPX); push_n(LP00V, T_PREP); push_n(HS0V, T_ZERO);
              push_n(GATE0V, T_PRE); push_n(CLKV, 1); mode = M_CLK;
            end else if (ppi.TXULPSCLK) begin
              push_n(URQV, T_LPX); push_n(ULPSV, 1); mode = M_ULPS;
            end
          M_CLK:
            if (!ppi.TXREQUESTHS) begin
              push_n(GATE0V, T_POST); push_n(HS0V, T_TRAIL); push_n(EXITV, T_EXIT);
              push_n(STOPV, 1); mode = M_STOP;
            end
          default:
            if (ppi.TXULPSEXIT) begin
              push_n(UEXITV, T_WAKE); push_n(STOPV, 1); mode = M_STOP;
            end
        endcase
      end
      if (q.size() != 0) expv = q.pop_front();
      else expv = (mode == M_CLK) ? CLKV : (mode == M_ULPS) ? ULPSV : STOPV;
    end
  end

  // LP line values are irrelevant while the LP driver is disabled.
  always @(negedge BYTECLK) begin
    if (cmp_en) begin
      logic [8:0] m;
      m = expv[6] ? 9'h1FF : 9'h07F;
      total++;
      if ((dut_vec & m) !== (expv & m)) begin
        bad++;
        $display("FAIL cycle_out t=%0t got=%b want=%b", $time, dut_vec, expv);
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return ppi.CLKACTIVE;
      1:       return ppi.STOPSTATE;
      default: return !ppi.ULPSACTIVENOT;
    endcase
  endfunction

  // Edges until the condition holds (sampled 1 time unit after each edge); -1 on timeout.
  task automatic wait_for(input int sel, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge BYTECLK); #1;
      if (cond(sel)) begin n = i; break; end
    end
  endtask

  initial begin
    int n;
    RST_N = 1'b0;
    ppi.TXREQUESTHS = 1'b0; ppi.TXULPSCLK = 1'b0; ppi.TXULPSEXIT = 1'b0;
    #23;
    chk("reset_vec", int'(dut_vec), int'(STOPV));
    @(negedge BYTECLK); RST_N = 1'b1; cmp_en = 1'b1;
    repeat (3) @(negedge BYTECLK);

    // HS entry with ULPS raised too: HS wins, ULPS ignored during HS_CLK.
    ppi.TXREQUESTHS = 1'b1; ppi.TXULPSCLK = 1'b1;
    @(posedge BYTECLK); #1;
    chk("prio_lp01", int'({ppi.DTXLPP, ppi.DTXLPN}), 1);
    wait_for(0, n);
    chk("hs_entry_latency", n + 1, 20);
    repeat (4) @(negedge BYTECLK);
    ppi.TXULPSCLK = 1'b0;

    // HS exit; a request raised during HS_EXIT waits for STOP.
    ppi.TXREQUESTHS = 1'b0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge BYTECLK); #1;
      if (i == 1) chk("clkactive_drop", int'(ppi.CLKACTIVE), 0);
      if (i == 12) ppi.TXREQUESTHS = 1'b1;
      if (ppi.STOPSTATE) begin n = i; break; end
    end
    chk("hs_exit_to_stop", n, 15);
    wait_for(0, n);
    chk("rerequest_latency", n, 20);

    // Asynchronous reset mid HS_CLK.
    @(posedge BYTECLK); #2;
    RST_N = 1'b0; ppi.TXREQUESTHS = 1'b0;
    #1;
    chk("async_reset_vec", int'(dut_vec), int'(STOPV));
    chk("async_reset_clkact", int'(ppi.CLKACTIVE), 0);
    @(negedge BYTECLK); RST_N = 1'b1;
    repeat (2) @(negedge BYTECLK);

    // One-cycle request pulse still runs the full sequence.
    ppi.TXREQUESTHS = 1'b1;
    @(posedge BYTECLK); #1; ppi.TXREQUESTHS = 1'b0;
    wait_for(0, n);
    chk("pulse_latency", n + 1, 20);
    @(posedge BYTECLK); #1;
    chk("pulse_clk_one_cycle", int'(ppi.CLKACTIVE), 0);
    wait_for(1, n);
    chk("pulse_exit_to_stop", n, 14);

    // ULPS round trip.
    @(negedge BYTECLK); ppi.TXULPSCLK = 1'b1;
    wait_for(2, n);
    chk("ulps_entry", n, 3);
    ppi.TXULPSCLK = 1'b0;
    repeat (5) @(negedge BYTECLK);
    chk("ulps_hold_on_clk_fall", int'(ppi.ULPSACTIVENOT), 0);
    ppi.TXULPSEXIT = 1'b1;
    wait_for(1, n);
    chk("ulps_wakeup", n, 21);
    chk("ulps_exit_ulpsn", int'(ppi.ULPSACTIVENOT), 1);
    ppi.TXULPSEXIT = 1'b0;

    // Random level traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge BYTECLK);
      if ($urandom_range(23, 0) == 0) ppi.TXREQUESTHS = ~ppi.TXREQUESTHS;
      if ($urandom_range(39, 0) == 0) ppi.TXULPSCLK   = ~ppi.TXULPSCLK;
      if ($urandom_range(29, 0) == 0) ppi.TXULPSEXIT  = ~ppi.TXULPSEXIT;
    end
    @(negedge BYTECLK);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
